// File: rtl/alu_seq_ctrl.sv
// Issue/sequencing controller around the SPARCv8 integer ALU; owns architectural ICC and Y.
// Optional ALU_SEQ_STATS_EN adds stat_ops / stat_busy activity counters.
//
// state | meaning
// IDLE  | no op in flight, ready for decode or a WRY write
// EXEC  | operands held on alu_*, latency counter running
// DONE  | result captured and held until writeback takes it
module alu_seq_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 34
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_tag,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_rd,
    output logic [4:0]  res_tag,
    output logic [1:0]  res_trap,
    input  logic        flush,
    input  logic        wry_valid,
    input  logic [31:0] wry_data,
    output logic [3:0]  icc,
    output logic [31:0] y,
`ifdef ALU_SEQ_STATS_EN
    output logic [31:0] stat_ops,
    output logic [31:0] stat_busy,
`endif
    output logic [5:0]  alu_op,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [3:0]  alu_icc_in,
    output logic [31:0] alu_y_in,
    input  logic [31:0] alu_rd,
    input  logic [3:0]  alu_icc_out,
    input  logic [31:0] alu_y_out,
    input  logic        alu_dbz,
    input  logic        alu_tov
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [4:0]      tag_q;
    logic            accept, capture, retire, wry_take, commit_ok;
    logic            is_cc, is_y;

    function automatic logic [CW-1:0] lat_m1(input logic [5:0] op);
        case (op)
            6'h0A, 6'h0B, 6'h1A, 6'h1B: lat_m1 = CW'(MUL_LAT - 1);
            6'h0E, 6'h0F, 6'h1E, 6'h1F: lat_m1 = CW'(DIV_LAT - 1);
            default:                    lat_m1 = '0;
        endcase
    endfunction

    assign req_ready  = !flush && ((state == IDLE) || (state == DONE && res_ready));
    assign accept     = req_valid && req_ready;
    assign capture    = (state == EXEC) && (cnt == '0);
    assign retire     = (state == DONE) && res_ready;
    assign wry_take   = wry_valid && (state == IDLE) && !accept;
    assign commit_ok  = !alu_dbz && !alu_tov;
    assign is_cc      = (alu_op[5:4] == 2'b01) || (alu_op >= 6'h20 && alu_op <= 6'h24);
    assign is_y       = (alu_op == 6'h0A) || (alu_op == 6'h0B) || (alu_op == 6'h1A) ||
                        (alu_op == 6'h1B) || (alu_op == 6'h24);
    assign alu_icc_in = icc;
    assign alu_y_in   = y;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    if (capture) state_nx = DONE;
            DONE:    if (res_ready) state_nx = accept ? EXEC : IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tag_q     <= '0;
            icc       <= '0;
            y         <= '0;
            res_valid <= 1'b0;
            res_rd    <= '0;
            res_tag   <= '0;
            res_trap  <= '0;
            alu_op    <= '0;
            alu_rs1   <= '0;
            alu_rs2   <= '0;
        end else begin
            state <= state_nx;
            if (wry_take) y <= wry_data;
            if (flush) begin
                res_valid <= 1'b0;
            end else begin
                if (retire) res_valid <= 1'b0;
                if (accept) begin
                    alu_op  <= req_op;
                    alu_rs1 <= req_rs1;
                    alu_rs2 <= req_rs2;
                    tag_q   <= req_tag;
                    cnt     <= lat_m1(req_op);
                end
                if (capture) begin
                    res_valid <= 1'b1;
                    res_rd    <= alu_rd;
                    res_tag   <= tag_q;
                    res_trap  <= {alu_tov, alu_dbz};
                    // Trapping ops leave architectural state untouched.
                    if (commit_ok && is_cc) icc <= alu_icc_out;
                    if (commit_ok && is_y)  y   <= alu_y_out;
                end else if (state == EXEC) begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops  <= '0;
            stat_busy <= '0;
        end else begin
            if (accept)        stat_ops  <= stat_ops + 32'd1;
            if (state != IDLE) stat_busy <= stat_busy + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: directed ops, queued expected results, separate monitor.
module tb_alu_seq_ctrl;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [5:0]  req_op = '0;
    logic [31:0] req_rs1 = '0, req_rs2 = '0;
    logic [4:0]  req_tag = '0;
    logic        res_valid, res_ready = 1'b1;
    logic [31:0] res_rd;
    logic [4:0]  res_tag;
    logic [1:0]  res_trap;
    logic        flush = 1'b0, wry_valid = 1'b0;
    logic [31:0] wry_data = '0;
    logic [3:0]  icc;
    logic [31:0] y;
    logic [5:0]  alu_op;
    logic [31:0] alu_rs1, alu_rs2, alu_y_in;
    logic [3:0]  alu_icc_in;
    logic [31:0] alu_rd, alu_y_out;
    logic [3:0]  alu_icc_out;
    logic        alu_dbz, alu_tov;
`ifdef ALU_SEQ_STATS_EN
    logic [31:0] stat_ops, stat_busy;
`endif

    alu_seq_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_rd(res_rd),
        .res_tag(res_tag), .res_trap(res_trap),
        .flush(flush), .wry_valid(wry_valid), .wry_data(wry_data),
        .icc(icc), .y(y),
`ifdef ALU_SEQ_STATS_EN
        .stat_ops(stat_ops), .stat_busy(stat_busy),
`endif
        .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_icc_in(alu_icc_in), .alu_y_in(alu_y_in),
        .alu_rd(alu_rd), .alu_icc_out(alu_icc_out), .alu_y_out(alu_y_out),
        .alu_dbz(alu_dbz), .alu_tov(alu_tov)
    );

    always #5 clk = ~clk;

    // Minimal ALU stand-in; non-committing paths return junk icc/y so a bad commit is visible.
    logic [63:0] prod;
    logic [32:0] sum;
    always_comb begin
        alu_rd      = '0;
        alu_icc_out = 4'h5;
        alu_y_out   = 32'h0BAD0BAD;
        alu_dbz     = 1'b0;
        alu_tov     = 1'b0;
        prod        = '0;
        sum         = '0;
        case (alu_op)
            6'h00: alu_rd = alu_rs1 + alu_rs2;
            6'h10: begin
                sum = {1'b0, alu_rs1} + {1'b0, alu_rs2};
                alu_rd = sum[31:0];
                alu_icc_out = {sum[31], sum[31:0] == 32'd0,
                               (alu_rs1[31] == alu_rs2[31]) && (sum[31] != alu_rs1[31]), sum[32]};
            end
            6'h0A: begin
                prod = {32'd0, alu_rs1} * {32'd0, alu_rs2};
                alu_rd = prod[31:0];
                alu_y_out = prod[63:32];
            end
            6'h1B: begin
                prod = {{32{alu_rs1[31]}}, alu_rs1} * {{32{alu_rs2[31]}}, alu_rs2};
                alu_rd = prod[31:0];
                alu_y_out = prod[63:32];
                alu_icc_out = {prod[31], prod[31:0] == 32'd0, 2'b00};
            end
            6'h0E: begin
                if (alu_rs2 == 32'd0) alu_dbz = 1'b1;
                else begin
                    prod = {alu_y_in, alu_rs1} / {32'd0, alu_rs2};
                    alu_rd = prod[31:0];
                end
            end
            default: ;
        endcase
    end

    typedef struct packed {
        logic [31:0] rd;
        logic [4:0]  tag;
        logic [1:0]  trap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got tag %0d rd %h expected none", res_tag, res_rd);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_rd", res_rd, mon_e.rd);
                check("res_tag", 32'(res_tag), 32'(mon_e.tag));
                check("res_trap", 32'(res_trap), 32'(mon_e.trap));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an op, waits for the accept edge, returns 1 time unit after it.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] erd, input logic [1:0] etrap,
                         output bit coinc);
        int n = 0;
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
        coinc = 1'b0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1 (tag %0d)", tag);
        end else begin
            coinc = res_valid;
            exp_q.push_back({erd, tag, etrap});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!res_valid && n < 100) begin
            step();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit c, c2;
        int n, vc;

        repeat (2) step();
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_rd", res_rd, 0);
        check("rst_res_tag", 32'(res_tag), 0);
        check("rst_icc", 32'(icc), 0);
        check("rst_y", y, 0);
        check("rst_alu_op", 32'(alu_op), 0);
        check("rst_req_ready", 32'(req_ready), 1);
        rst = 1'b0;
        step();

        // ADDcc overflow into the sign bit
        issue(6'h10, 32'h7FFFFFFF, 32'h1, 5'd1, 32'h80000000, 2'b00, c);
        wait_valid(n);
        check("addcc_lat", 32'(n), 1);
        check("addcc_icc", 32'(icc), 32'hA);
        check("addcc_y", y, 0);
        step();

        // UMUL: high word lands in Y
        issue(6'h0A, 32'hFFFFFFFF, 32'h2, 5'd2, 32'hFFFFFFFE, 2'b00, c);
        check("umul_ready_exec", 32'(req_ready), 0);
        wait_valid(n);
        check("umul_lat", 32'(n), MUL_LAT);
        check("umul_y", y, 32'h1);
        check("umul_icc", 32'(icc), 32'hA);
        step();

        // UDIV by zero: trap, no commit
        issue(6'h0E, 32'd10, 32'd0, 5'd3, 32'h0, 2'b01, c);
        wait_valid(n);
        check("udiv_lat", 32'(n), DIV_LAT);
        check("udiv_icc", 32'(icc), 32'hA);
        check("udiv_y", y, 32'h1);
        step();

        // back-to-back ADDs
        issue(6'h00, 32'd5, 32'd6, 5'd4, 32'd11, 2'b00, c);
        issue(6'h00, 32'd100, 32'd23, 5'd5, 32'd123, 2'b00, c2);
        check("b2b_coincident", 32'(c2), 1);
        wait_valid(n);
        check("b2b_lat2", 32'(n), 1);
        step();

        // result held while writeback stalls
        res_ready = 1'b0;
        issue(6'h00, 32'h1000, 32'h0234, 5'd6, 32'h1234, 2'b00, c);
        wait_valid(n);
        repeat (3) step();
        check("hold_valid", 32'(res_valid), 1);
        check("hold_rd", res_rd, 32'h1234);
        check("hold_tag", 32'(res_tag), 6);
        check("hold_req_ready", 32'(req_ready), 0);
        res_ready = 1'b1;
        step();
        check("hold_release", 32'(res_valid), 0);

        // unknown opcode: one-cycle pass-through, no commit
        issue(6'h3F, 32'd1, 32'd2, 5'd7, 32'h0, 2'b00, c);
        wait_valid(n);
        check("unk_lat", 32'(n), 1);
        check("unk_icc", 32'(icc), 32'hA);
        check("unk_y", y, 32'h1);
        step();

        // flush mid-divide, then WRY
        issue(6'h0E, 32'd100, 32'd5, 5'd8, 32'h0, 2'b00, c);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        void'(exp_q.pop_back());
        vc = 0;
        repeat (40) begin
            step();
            if (res_valid) vc++;
        end
        check("flush_no_result", 32'(vc), 0);
        wry_valid = 1'b1; wry_data = 32'h12345678;
        step();
        wry_valid = 1'b0;
        check("wry_y", y, 32'h12345678);

        // WRY while busy is ignored
        issue(6'h00, 32'd1, 32'd1, 5'd9, 32'd2, 2'b00, c);
        wry_valid = 1'b1; wry_data = 32'hAAAAAAAA;
        step();
        wry_valid = 1'b0;
        step();
        check("wry_busy_ignored", y, 32'h12345678);

        // reset during SMULcc
        issue(6'h1B, 32'd3, 32'd5, 5'd10, 32'd15, 2'b00, c);
        step();
        rst = 1'b1;
        void'(exp_q.pop_back());
        step();
        check("rst_exec_icc", 32'(icc), 0);
        check("rst_exec_y", y, 0);
        check("rst_exec_valid", 32'(res_valid), 0);
        check("rst_exec_rd", res_rd, 0);
        check("rst_exec_alu_op", 32'(alu_op), 0);
        check("rst_exec_ready", 32'(req_ready), 1);
        rst = 1'b0;
        repeat (3) step();

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Issue/sequencing controller wrapped around the SPARCv8 integer ALU. It accepts one ALU operation at a time from decode over a valid/ready handshake, holds the operands stable for the op's latency, and captures rd/icc/Y and the trap flags. It owns the architectural ICC and Y registers, committing them only for trap-free ops, and returns results to writeback over a second valid/ready handshake.

Parameters:
MUL_LAT, 4, cycles from accept to result for UMUL/SMUL/UMULcc/SMULcc (min 1)
DIV_LAT, 34, cycles from accept to result for UDIV/SDIV/UDIVcc/SDIVcc (min 1)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  decode presents an op
req_ready  out  1  controller can accept
req_op  in  6  ALU opcode
req_rs1  in  32  operand 1
req_rs2  in  32  operand 2, already sign-extended
req_tag  in  5  destination register, returned unchanged
res_valid  out  1  result available
res_ready  in  1  writeback accepts the result
res_rd  out  32  result value
res_tag  out  5  tag of the completed op
res_trap  out  2  bit0 = division_by_zero, bit1 = tag_overflow
flush  in  1  kill any in-flight or pending op
wry_valid  in  1  WRY write request
wry_data  in  32  WRY value
icc  out  4  architectural NZVC
y  out  32  architectural Y
alu_op  out  6  to ALU alu_opcode
alu_rs1, alu_rs2  out  32  to ALU operands
alu_icc_in  out  4  equals icc
alu_y_in  out  32  equals y
alu_rd, alu_icc_out, alu_y_out  in  32/4/32  from ALU
alu_dbz, alu_tov  in  1/1  ALU trap outputs

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; icc=0, y=0, res_valid=0, res_rd=0, res_tag=0, res_trap=0, alu_op=0, alu_rs1=0, alu_rs2=0, counter=0. A reset mid-operation abandons the op; nothing is committed.
- States: IDLE, EXEC, DONE.
- req_ready = (state==IDLE) or (state==DONE and res_ready); it is 0 while flush=1. An accept (req_valid and req_ready) latches op/rs1/rs2/tag into the alu_* registers, loads counter = LAT-1, and moves to EXEC.
- LAT is MUL_LAT for 0x0A/0x0B/0x1A/0x1B, DIV_LAT for 0x0E/0x0F/0x1E/0x1F, and 1 for all other opcodes.
- EXEC: alu_* holds steady. The counter decrements each cycle. At counter==0 the controller samples the ALU outputs, sets res_valid=1, and moves to DONE.
- Result timing: res_valid rises exactly LAT cycles after the accept edge.
- Commit happens on the capture edge and only if alu_dbz=0 and alu_tov=0:
  - icc <= alu_icc_out for cc-setting ops (0x10-0x1F, 0x20-0x24).
  - y <= alu_y_out for 0x0A/0x0B/0x1A/0x1B/0x24.
  - On a trap, icc and y are unchanged and res_trap = {tov, dbz}.
- DONE: res_rd, res_tag and res_trap are held until res_ready. On res_ready with no new accept, go to IDLE and drop res_valid. On res_ready with a simultaneous accept, go straight to EXEC (back-to-back, no bubble).
- flush: has the highest priority after rst. It forces IDLE and res_valid=0 on the next edge. An op still in EXEC commits nothing; a DONE result that was already committed stays committed.
- WRY: accepted only when state==IDLE and there is no accept in the same cycle; then y <= wry_data on that edge. Otherwise it is ignored; decode must hold it until the controller is idle.
- Unknown opcodes pass through with LAT=1 and are not committed.

Optional Feature:
ALU_SEQ_STATS_EN:
- Defined: adds outputs stat_ops (32 bits, increments on each accept) and stat_busy (32 bits, increments each cycle state!=IDLE). Both reset to 0 on rst, wrap at 2^32, and are not cleared by flush.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- ADDcc with rs1=0x7FFFFFFF, rs2=1, res_ready held 1 -> res_valid one cycle after accept, res_rd=0x80000000, icc=4'b1010, y unchanged.
- UMUL with rs1=0xFFFFFFFF, rs2=2 -> res_valid exactly MUL_LAT cycles after accept, res_rd=0xFFFFFFFE, y=0x00000001, req_ready=0 during EXEC.
- UDIV with rs2=0 -> res_trap=2'b01 after DIV_LAT cycles; icc and y keep their pre-op values.
- Two ADD ops back-to-back with res_ready=1 -> second accepted on the same edge the first retires; results arrive on consecutive cycles with correct tags.
- flush two cycles into a UDIV, then a WRY of 0x12345678 -> no res_valid for the divide; y=0x12345678 after the WRY edge.
- rst asserted during EXEC of SMULcc -> next cycle all outputs at reset values, icc=0, y=0, req_ready=1.
